// File: rtl/tlb_refill_walker_if.sv
// Bundle of the miss request, PTE memory port and fill/fault result signals
// shared between the TLB side and the refill walker.
interface tlb_refill_walker_if #(
  parameter int unsigned VA_WIDTH  = 32,
  parameter int unsigned PA_WIDTH  = 32,
  parameter int unsigned PAGE_BITS = 12,
  parameter int unsigned PTE_WIDTH = 32
);
  // Miss request
  logic                          miss_valid;
  logic                          miss_ready;
  logic [VA_WIDTH-1:0]           miss_vaddr;
  logic                          miss_is_write;
  logic                          mode;
  logic [PA_WIDTH-1:0]           os_offset;
  logic [PA_WIDTH-1:0]           ptbr;

  // PTE memory port
  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic [PA_WIDTH-1:0]           mem_req_addr;
  logic                          mem_resp_valid;
  logic [PTE_WIDTH-1:0]          mem_resp_data;

  // Result
  logic                          fill_valid;
  logic [VA_WIDTH-PAGE_BITS-1:0] fill_vpn;
  logic [PA_WIDTH-PAGE_BITS-1:0] fill_ppn;
  logic [PA_WIDTH-1:0]           fill_paddr;
  logic                          fault_valid;
  logic [1:0]                    fault_cause;
  logic [VA_WIDTH-1:0]           fault_vaddr;
  logic                          busy;

  // TLB/memory side
  modport master (
    output miss_valid, miss_vaddr, miss_is_write, mode, os_offset, ptbr,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  miss_ready, mem_req_valid, mem_req_addr,
    input  fill_valid, fill_vpn, fill_ppn, fill_paddr,
    input  fault_valid, fault_cause, fault_vaddr, busy
  );

  // Walker side
  modport slave (
    input  miss_valid, miss_vaddr, miss_is_write, mode, os_offset, ptbr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output miss_ready, mem_req_valid, mem_req_addr,
    output fill_valid, fill_vpn, fill_ppn, fill_paddr,
    output fault_valid, fault_cause, fault_vaddr, busy
  );
endinterface

// File: rtl/tlb_refill_walker.sv
// TLB refill engine: flat offset translation or single-level page-table walk,
// returning a one-cycle fill or fault pulse per accepted miss.
module tlb_refill_walker #(
  parameter int unsigned VA_WIDTH  = 32,
  parameter int unsigned PA_WIDTH  = 32,
  parameter int unsigned PAGE_BITS = 12,
  parameter int unsigned PTE_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 256
) (
  input logic                clk,
  input logic                reset,
  tlb_refill_walker_if.slave bus
);

  localparam int unsigned VPN_W     = VA_WIDTH - PAGE_BITS;
  localparam int unsigned PPN_W     = PA_WIDTH - PAGE_BITS;
  localparam int unsigned PTE_SHIFT = $clog2(PTE_WIDTH / 8);
  localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       CAUSE_INVALID = 2'b01;
  localparam logic [1:0]       CAUSE_WPROT   = 2'b10;
  localparam logic [1:0]       CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [VA_WIDTH-1:0] vaddr_q, vaddr_d;
  logic                is_write_q, is_write_d;
  logic [PA_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                is_fault_q, is_fault_d;
  logic [VPN_W-1:0]    fill_vpn_q, fill_vpn_d;
  logic [PA_WIDTH-1:0] fill_paddr_q, fill_paddr_d;
  logic [1:0]          cause_q, cause_d;
  logic [VA_WIDTH-1:0] fault_vaddr_q, fault_vaddr_d;

  logic [PA_WIDTH-1:0] flat_paddr;
  logic [PA_WIDTH-1:0] pte_addr;
  logic [PA_WIDTH-1:0] walk_paddr;
  logic [PPN_W-1:0]    pte_ppn;
  logic                pte_v;
  logic                pte_w;

  // Size casts give the zero-extend/truncate-to-PA_WIDTH behaviour of both sums
  assign flat_paddr = PA_WIDTH'(bus.miss_vaddr) + bus.os_offset;
  assign pte_addr   = bus.ptbr + (PA_WIDTH'(bus.miss_vaddr >> PAGE_BITS) << PTE_SHIFT);

  assign pte_v      = bus.mem_resp_data[0];
  assign pte_w      = bus.mem_resp_data[1];
  assign pte_ppn    = bus.mem_resp_data[PAGE_BITS +: PPN_W];
  assign walk_paddr = {pte_ppn, vaddr_q[PAGE_BITS-1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      vaddr_q       <= '0;
      is_write_q    <= 1'b0;
      req_addr_q    <= '0;
      cnt_q         <= '0;
      is_fault_q    <= 1'b0;
      fill_vpn_q    <= '0;
      fill_paddr_q  <= '0;
      cause_q       <= '0;
      fault_vaddr_q <= '0;
    end else begin
      state_q       <= state_d;
      vaddr_q       <= vaddr_d;
      is_write_q    <= is_write_d;
      req_addr_q    <= req_addr_d;
      cnt_q         <= cnt_d;
      is_fault_q    <= is_fault_d;
      fill_vpn_q    <= fill_vpn_d;
      fill_paddr_q  <= fill_paddr_d;
      cause_q       <= cause_d;
      fault_vaddr_q <= fault_vaddr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    vaddr_d       = vaddr_q;
    is_write_d    = is_write_q;
    req_addr_d    = req_addr_q;
    cnt_d         = cnt_q;
    is_fault_d    = is_fault_q;
    fill_vpn_d    = fill_vpn_q;
    fill_paddr_d  = fill_paddr_q;
    cause_d       = cause_q;
    fault_vaddr_d = fault_vaddr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.miss_valid) begin
          vaddr_d    = bus.miss_vaddr;
          is_write_d = bus.miss_is_write;
          if (!bus.mode) begin
            is_fault_d   = 1'b0;
            fill_vpn_d   = bus.miss_vaddr[VA_WIDTH-1:PAGE_BITS];
            fill_paddr_d = flat_paddr;
            state_d      = DONE;
          end else begin
            req_addr_d = pte_addr;
            state_d    = REQ;
          end
        end
      end

      REQ: begin
        if (bus.mem_req_ready) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        // A response on the terminal count is checked first, so it beats the timeout
        if (bus.mem_resp_valid) begin
          state_d = DONE;
          if (!pte_v) begin
            is_fault_d    = 1'b1;
            cause_d       = CAUSE_INVALID;
            fault_vaddr_d = vaddr_q;
          end else if (is_write_q && !pte_w) begin
            is_fault_d    = 1'b1;
            cause_d       = CAUSE_WPROT;
            fault_vaddr_d = vaddr_q;
          end else begin
            is_fault_d   = 1'b0;
            fill_vpn_d   = vaddr_q[VA_WIDTH-1:PAGE_BITS];
            fill_paddr_d = walk_paddr;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d       = DONE;
          is_fault_d    = 1'b1;
          cause_d       = CAUSE_TIMEOUT;
          fault_vaddr_d = vaddr_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.miss_ready    = (state_q == IDLE);
  assign bus.busy          = (state_q != IDLE);
  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_addr  = req_addr_q;

  assign bus.fill_valid    = (state_q == DONE) && !is_fault_q;
  assign bus.fill_vpn      = fill_vpn_q;
  assign bus.fill_ppn      = fill_paddr_q[PA_WIDTH-1:PAGE_BITS];
  assign bus.fill_paddr    = fill_paddr_q;

  assign bus.fault_valid   = (state_q == DONE) && is_fault_q;
  assign bus.fault_cause   = cause_q;
  assign bus.fault_vaddr   = fault_vaddr_q;

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Self-checking bench for tlb_refill_walker: vector table driven through a
// scoreboard, plus hand sequences for back-to-back misses and reset mid-walk.
module tb_tlb_refill_walker;

  localparam int unsigned TO = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tlb_refill_walker_if #(
    .VA_WIDTH (32),
    .PA_WIDTH (32),
    .PAGE_BITS(12),
    .PTE_WIDTH(32)
  ) bus ();

  tlb_refill_walker #(
    .VA_WIDTH (32),
    .PA_WIDTH (32),
    .PAGE_BITS(12),
    .PTE_WIDTH(32),
    .TIMEOUT  (TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        mode;
    logic        wr;
    logic [31:0] vaddr;
    logic [31:0] off;
    logic [31:0] ptbr;
    int          rd;        // cycles of mem_req_ready low in REQ
    int          rdl;       // WAIT cycles before response; >= TO means none
    logic        stale;     // drive mem_resp_valid during REQ
    logic [31:0] pte;
    logic        is_fault;
    logic [1:0]  cause;
    logic [31:0] exp_req;
    logic [31:0] exp_paddr;
  } vec_t;

  typedef struct {
    logic        is_fault;
    logic [1:0]  cause;
    logic [31:0] paddr;
    logic [31:0] vaddr;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  vec_t vecs[11];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
  endtask

  // Scoreboard monitor: every pulse must match the oldest expectation
  logic pulse_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (pulse_prev) begin
      check("busy_after_pulse", 32'(bus.busy), 32'd0);
      check("ready_after_pulse", 32'(bus.miss_ready), 32'd1);
    end
    pulse_prev = bus.fill_valid | bus.fault_valid;
    if (bus.fill_valid || bus.fault_valid) begin
      check("single_pulse", 32'(bus.fill_valid & bus.fault_valid), 32'd0);
      if (sbq.size() == 0) begin
        fail_now("unexpected_pulse");
      end else begin
        e = sbq.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("fault_valid", 32'(bus.fault_valid), 32'(e.is_fault));
        if (e.is_fault) begin
          check("fault_cause", 32'(bus.fault_cause), 32'(e.cause));
          check("fault_vaddr", bus.fault_vaddr, e.vaddr);
        end else begin
          check("fill_paddr", bus.fill_paddr, e.paddr);
          check("fill_vpn", 32'(bus.fill_vpn), e.vaddr >> 12);
          check("fill_ppn", 32'(bus.fill_ppn), e.paddr >> 12);
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.busy && n < int'(TO) + 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) fail_now(name);
  endtask

  task automatic run_vec(input vec_t v);
    int   lat;
    int   n;
    exp_t e;
    @(negedge clk);
    bus.miss_valid    = 1'b1;
    bus.miss_vaddr    = v.vaddr;
    bus.miss_is_write = v.wr;
    bus.mode          = v.mode;
    bus.os_offset     = v.off;
    bus.ptbr          = v.ptbr;
    n = 0;
    while (!bus.miss_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.miss_ready) begin
      fail_now("accept_timeout");
      bus.miss_valid = 1'b0;
      return;
    end
    if (!v.mode)          lat = 1;
    else if (v.rdl >= int'(TO)) lat = 2 + v.rd + int'(TO);
    else                  lat = 3 + v.rd + v.rdl;
    e = '{v.is_fault, v.cause, v.exp_paddr, v.vaddr, cyc + lat};
    sbq.push_back(e);
    @(negedge clk);
    // Disturb the accept-time inputs; the walk must not notice
    bus.miss_valid = 1'b0;
    bus.mode       = ~v.mode;
    bus.ptbr       = ~v.ptbr;
    bus.os_offset  = v.off ^ 32'h5A5A_0000;
    bus.miss_vaddr = '0;
    if (v.mode) begin
      for (int i = 0; i <= v.rd; i++) begin
        check("req_valid", 32'(bus.mem_req_valid), 32'd1);
        check("req_addr", bus.mem_req_addr, v.exp_req);
        bus.mem_req_ready  = (i == v.rd);
        bus.mem_resp_valid = v.stale;
        bus.mem_resp_data  = '0;
        @(negedge clk);
      end
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      check("wait_req_low", 32'(bus.mem_req_valid), 32'd0);
      for (int j = 0; j < int'(TO); j++) begin
        if (j == v.rdl) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = v.pte;
          @(negedge clk);
          bus.mem_resp_valid = 1'b0;
          break;
        end
        @(negedge clk);
      end
    end
    wait_idle("idle_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    //          mode wr    vaddr          off            ptbr           rd  rdl      stale pte            flt   cause  exp_req        exp_paddr
    vecs[0]  = '{1'b0, 1'b0, 32'h0000_1234, 32'h1000_0000, 32'h0,        0,  0,       1'b0, 32'h0,         1'b0, 2'b00, 32'h0,         32'h1000_1234};
    vecs[1]  = '{1'b0, 1'b0, 32'hFFFF_F010, 32'h0000_2000, 32'h0,        0,  0,       1'b0, 32'h0,         1'b0, 2'b00, 32'h0,         32'h0000_1010};
    vecs[2]  = '{1'b1, 1'b0, 32'h0040_2ABC, 32'h0,         32'h8000_0000, 0,  0,       1'b0, 32'h0001_2003, 1'b0, 2'b00, 32'h8000_1008, 32'h0001_2ABC};
    vecs[3]  = '{1'b1, 1'b0, 32'h0040_2ABC, 32'h0,         32'h8000_0000, 0,  0,       1'b0, 32'h0001_2000, 1'b1, 2'b01, 32'h8000_1008, 32'h0};
    vecs[4]  = '{1'b1, 1'b1, 32'h0040_2ABC, 32'h0,         32'h8000_0000, 0,  0,       1'b0, 32'h0001_2001, 1'b1, 2'b10, 32'h8000_1008, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 32'h0040_2ABC, 32'h0,         32'h8000_0000, 0,  2,       1'b0, 32'h0001_2003, 1'b0, 2'b00, 32'h8000_1008, 32'h0001_2ABC};
    vecs[6]  = '{1'b1, 1'b1, 32'h0040_2ABC, 32'h0,         32'h8000_0000, 1,  0,       1'b0, 32'h0001_2002, 1'b1, 2'b01, 32'h8000_1008, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'hABCD_E123, 32'h0,         32'h0010_0000, 5,  3,       1'b1, 32'hDEAD_B001, 1'b0, 2'b00, 32'h003A_F378, 32'hDEAD_B123};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0FFF, 32'h0,         32'h0000_0000, 0,  int'(TO) - 1, 1'b0, 32'h0005_5003, 1'b0, 2'b00, 32'h0000_0000, 32'h0005_5FFF};
    vecs[9]  = '{1'b1, 1'b0, 32'h1234_5678, 32'h0,         32'h4000_0000, 5,  int'(TO), 1'b0, 32'h0,         1'b1, 2'b11, 32'h4004_8D14, 32'h0};
    vecs[10] = '{1'b0, 1'b1, 32'h7654_3210, 32'h0123_4000, 32'h0,        0,  0,       1'b0, 32'h0,         1'b0, 2'b00, 32'h0,         32'h7777_7210};

    reset              = 1'b1;
    bus.miss_valid     = 1'b0;
    bus.miss_vaddr     = '0;
    bus.miss_is_write  = 1'b0;
    bus.mode           = 1'b0;
    bus.os_offset      = '0;
    bus.ptbr           = '0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    repeat (2) @(negedge clk);
    check("rst_miss_ready", 32'(bus.miss_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("rst_req_addr", bus.mem_req_addr, 32'd0);
    check("rst_fill_paddr", bus.fill_paddr, 32'd0);
    check("rst_fault_cause", 32'(bus.fault_cause), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 11; k++) run_vec(vecs[k]);

    // Back-to-back flat misses with miss_valid held high
    @(negedge clk);
    bus.miss_valid = 1'b1;
    bus.mode       = 1'b0;
    bus.os_offset  = 32'h2000_0000;
    bus.miss_vaddr = 32'h0000_3456;
    check("b2b_first_ready", 32'(bus.miss_ready), 32'd1);
    e = '{1'b0, 2'b00, 32'h2000_3456, 32'h0000_3456, cyc + 1};
    sbq.push_back(e);
    @(negedge clk);
    check("b2b_stall_ready", 32'(bus.miss_ready), 32'd0);
    bus.miss_vaddr = 32'h0000_7890;
    @(negedge clk);
    check("b2b_second_ready", 32'(bus.miss_ready), 32'd1);
    e = '{1'b0, 2'b00, 32'h2000_7890, 32'h0000_7890, cyc + 1};
    sbq.push_back(e);
    @(negedge clk);
    bus.miss_valid = 1'b0;
    wait_idle("b2b_idle");

    // Reset pulsed during WAIT, then a late response
    @(negedge clk);
    bus.miss_valid = 1'b1;
    bus.mode       = 1'b1;
    bus.ptbr       = 32'h8000_0000;
    bus.miss_vaddr = 32'h0040_2ABC;
    @(negedge clk);
    bus.miss_valid    = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    check("rstw_in_wait", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset              = 1'b0;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = 32'h0001_2003;
    @(negedge clk);
    bus.mem_resp_valid = 1'b0;
    check("rstw_fill_valid", 32'(bus.fill_valid), 32'd0);
    check("rstw_busy", 32'(bus.busy), 32'd0);
    check("rstw_miss_ready", 32'(bus.miss_ready), 32'd1);
    check("rstw_req_addr", bus.mem_req_addr, 32'd0);
    check("rstw_fill_paddr", bus.fill_paddr, 32'd0);
    check("rstw_fill_vpn", 32'(bus.fill_vpn), 32'd0);
    check("rstw_fault_vaddr", bus.fault_vaddr, 32'd0);
    repeat (3) @(negedge clk);
    run_vec(vecs[2]);

    repeat (5) @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      fail_now("missing_pulse");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
